// File: rtl/hs_rx_seq_sink_if.sv
// Valid/ready bundle between the CDC receiver, the sink FIFO input and the downstream consumer.
// The master side drives words in and accepts the FIFO head; the slave side is the sink.
interface hs_rx_seq_sink_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/hs_rx_seq_sink.sv
// Receive-domain sink behind the handshake CDC: FWFT FIFO plus an incrementing-sequence checker
// that counts accepted words and sequence errors for bring-up of the multibit CDC path.
module hs_rx_seq_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic               clk_receiver,
    input  logic               rst,
    hs_rx_seq_sink_if.slave    bus,
    input  logic               clr_err,
    output logic               locked,
    output logic               err_flag,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [15:0]        word_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {HUNT, LOCK} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] exp_next;
    logic [ERR_W-1:0] err_cnt_next;
    logic             err_flag_next;

    assign bus.in_ready  = !rst && (count != FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign locked        = (state == LOCK);

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk_receiver) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_receiver) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                word_cnt <= word_cnt + 16'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_receiver) begin
        if (rst) begin
            state    <= HUNT;
            exp_word <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_next;
            exp_word <= exp_next;
            err_cnt  <= err_cnt_next;
            err_flag <= err_flag_next;
        end
    end

    // A clear and a mismatch in the same cycle leave exactly one error recorded.
    always_comb begin
        state_next    = state;
        exp_next      = exp_word;
        err_cnt_next  = err_cnt;
        err_flag_next = err_flag;
        if (clr_err) begin
            err_cnt_next  = '0;
            err_flag_next = 1'b0;
        end
        if (push) begin
            exp_next = bus.in_data + WIDTH'(1);
            case (state)
                HUNT: begin
                    state_next = LOCK;
                end
                LOCK: begin
                    if (bus.in_data != exp_word) begin
                        err_flag_next = 1'b1;
                        if (err_cnt_next != '1) begin
                            err_cnt_next = err_cnt_next + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hs_rx_seq_sink.sv
// Self-checking bench for hs_rx_seq_sink: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_hs_rx_seq_sink;
    localparam int DEPTH = 4;

    logic        clk_receiver;
    logic        rst;
    logic        clr_err;
    logic        locked;
    logic        err_flag;
    logic [7:0]  err_cnt;
    logic [15:0] word_cnt;

    int          n_checks;
    int          n_fail;
    bit          started;

    hs_rx_seq_sink_if #(.WIDTH(8)) bus ();

    hs_rx_seq_sink #(.WIDTH(8), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk_receiver (clk_receiver),
        .rst          (rst),
        .bus          (bus),
        .clr_err      (clr_err),
        .locked       (locked),
        .err_flag     (err_flag),
        .err_cnt      (err_cnt),
        .word_cnt     (word_cnt)
    );

    initial begin
        clk_receiver = 1'b0;
        forever #5 clk_receiver = ~clk_receiver;
    end

    // Behavioural model: FIFO contents as a queue, checker as "last accepted word" plus counters.
    logic [7:0]  m_q [$];
    bit          m_locked;
    logic [7:0]  m_last;
    int          m_err;
    bit          m_flag;
    int          m_words;

    always @(posedge clk_receiver) begin
        bit         do_push;
        bit         do_pop;
        logic [7:0] d;
        if (started) begin
            d       = bus.in_data;
            do_push = bus.in_valid && !rst && (m_q.size() != DEPTH);
            do_pop  = (m_q.size() != 0) && bus.out_ready;
            if (rst) begin
                m_q.delete();
                m_locked = 0;
                m_last   = 8'h00;
                m_err    = 0;
                m_flag   = 0;
                m_words  = 0;
            end else begin
                if (clr_err) begin
                    m_err  = 0;
                    m_flag = 0;
                end
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    m_q.push_back(d);
                    m_words = (m_words + 1) % 65536;
                    if (m_locked && (int'(d) != (int'(m_last) + 1) % 256)) begin
                        m_err  = (m_err < 255) ? m_err + 1 : 255;
                        m_flag = 1;
                    end
                    m_locked = 1;
                    m_last   = d;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_receiver) begin
        if (started) begin
            checkOutput("model in_ready", 32'(bus.in_ready), 32'(!rst && (m_q.size() != DEPTH)));
            checkOutput("model out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) checkOutput("model out_data", 32'(bus.out_data), 32'(m_q[0]));
            checkOutput("model locked", 32'(locked), 32'(m_locked));
            checkOutput("model err_flag", 32'(err_flag), 32'(m_flag));
            checkOutput("model err_cnt", 32'(err_cnt), 32'(m_err));
            checkOutput("model word_cnt", 32'(word_cnt), 32'(m_words));
        end
    end

    // Inputs are held for exactly one rising edge; returns just after that edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit ordy, input bit clr, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clr_err       = clr;
        rst           = r;
        @(posedge clk_receiver);
        #1;
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] d;
        n_checks = 0;
        n_fail   = 0;
        started  = 1;

        // Reset held for three edges, then released.
        repeat (3) applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("rst in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst locked", 32'(locked), 32'd0);
        checkOutput("rst err_cnt", 32'(err_cnt), 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h10 + 8'(i), 1, 0, 0);
            checkOutput("stream out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stream out_data", 32'(bus.out_data), 32'h10 + 32'(i));
            checkOutput("stream locked", 32'(locked), 32'd1);
        end
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("stream word_cnt", 32'(word_cnt), 32'd4);
        checkOutput("stream err_cnt", 32'(err_cnt), 32'd0);

        // Fill to full, hold off a fifth word, free one slot, then accept it.
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h14 + 8'(i), 0, 0, 0);
        checkOutput("full in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1, 8'h18, 0, 0, 0);
        checkOutput("full hold data", 32'(bus.out_data), 32'h14);
        checkOutput("full hold in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1, 8'h18, 1, 0, 0);
        checkOutput("after pop in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("after pop out_data", 32'(bus.out_data), 32'h15);
        applyStimulus(1, 8'h18, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain order", 32'(bus.out_data), 32'h15 + 32'(k));
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("drain out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain word_cnt", 32'(word_cnt), 32'd9);
        checkOutput("drain err_cnt", 32'(err_cnt), 32'd0);

        // Wrap-around of the data value is still in sequence.
        applyStimulus(0, 8'h00, 1, 0, 1);
        foreach (seq[i]) ;
        applyStimulus(1, 8'hFE, 1, 0, 0);
        applyStimulus(1, 8'hFF, 1, 0, 0);
        applyStimulus(1, 8'h00, 1, 0, 0);
        applyStimulus(1, 8'h01, 1, 0, 0);
        checkOutput("wrap err_flag", 32'(err_flag), 32'd0);
        checkOutput("wrap err_cnt", 32'(err_cnt), 32'd0);

        // Gap in the sequence, resync, then clear; finally a clear coinciding with a mismatch.
        applyStimulus(0, 8'h00, 1, 0, 1);
        applyStimulus(1, 8'h05, 1, 0, 0);
        applyStimulus(1, 8'h06, 1, 0, 0);
        applyStimulus(1, 8'h09, 1, 0, 0);
        checkOutput("gap err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("gap err_flag", 32'(err_flag), 32'd1);
        applyStimulus(1, 8'h0A, 1, 0, 0);
        checkOutput("resync err_cnt", 32'(err_cnt), 32'd1);
        applyStimulus(0, 8'h00, 1, 1, 0);
        checkOutput("clr err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("clr err_flag", 32'(err_flag), 32'd0);
        checkOutput("clr locked", 32'(locked), 32'd1);
        applyStimulus(1, 8'h50, 1, 1, 0);
        checkOutput("clr+err err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("clr+err err_flag", 32'(err_flag), 32'd1);

        // Error counter saturates at all-ones.
        applyStimulus(0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 300; i++) applyStimulus(1, (i % 2 == 0) ? 8'h00 : 8'h80, 1, 0, 0);
        checkOutput("sat err_cnt", 32'(err_cnt), 32'd255);
        checkOutput("sat err_flag", 32'(err_flag), 32'd1);

        // Reset with words queued discards them and re-hunts.
        applyStimulus(0, 8'h00, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h30 + 8'(i), 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid rst locked", 32'(locked), 32'd0);
        checkOutput("mid rst word_cnt", 32'(word_cnt), 32'd0);
        applyStimulus(1, 8'h77, 0, 0, 0);
        checkOutput("rehunt locked", 32'(locked), 32'd1);
        checkOutput("rehunt err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rehunt word_cnt", 32'(word_cnt), 32'd1);

        // Randomized traffic, mostly in sequence, with occasional clears and resets.
        seq = 8'h78;
        for (int i = 0; i < 4000; i++) begin
            bit v;
            v = ($urandom_range(0, 99) < 70);
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : seq;
            applyStimulus(v, d, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 199) == 0));
            if (v) seq = d + 8'd1;
        end

        applyStimulus(0, 8'h00, 1, 0, 0);
        @(negedge clk_receiver);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
